// File: rtl/uart_msg_pkg.sv
// Shared types for the UART message streamer: FSM state encoding and ASCII line terminators.
// The CR/LF states are only reachable when UART_MSG_CRLF_EN is defined.
package uart_msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        CR,
        LF,
        FIN
    } msg_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_msg_streamer_if.sv
// Byte handoff towards a UART transmitter: tx_data is held with tx_start until tx_ready.
// The master side owns tx_start/tx_data; the transmitter (slave) owns tx_ready.
interface uart_msg_streamer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_start, output tx_data, input tx_ready);
    modport slave  (input tx_start, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_msg_buf.sv
// Purpose: DEPTH x 8 simple dual-port message RAM.
// Latency: write lands next cycle; read data registered, 1 cycle after address.
// Backpressure: none; the caller gates the write strobe.
module uart_msg_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_msg_streamer.sv
// Purpose: streams buffer bytes 0..len-1 to a UART transmitter on a trig rising edge (UART_MSG_CRLF_EN appends CR LF).
// Latency: busy 1 cycle after the trig edge, first tx_start 2 cycles after; at least 2 cycles between handoffs.
// Backpressure: each byte is held on tx_start/tx_data until tx_ready; abort drops the byte on the wire.
module uart_msg_streamer
    import uart_msg_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          trig,
    input  logic          abort,
    input  logic [LW-1:0] len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_drop,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    uart_msg_streamer_if.master tx
);

    msg_state_e    state;
    logic          trig_q;
    logic [LW-1:0] len_q;
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          trig_edge;
    logic          handoff;
    logic          last_byte;
    logic [LW-1:0] len_clamped;

    assign trig_edge   = trig & ~trig_q;
    assign handoff     = tx.tx_start & tx.tx_ready;
    assign last_byte   = (LW'(idx) + LW'(1)) == len_q;
    assign len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

    // Prefetch: address 0 while idle, idx+1 while sending, so READ always finds its byte in rd_data.
    assign rd_addr = (state == SEND) ? idx + AW'(1) : '0;

    uart_msg_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .sys_clk (sys_clk),
        .we      (wr_en & ~busy),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (rd_addr),
        .rdata   (rd_data)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            trig_q      <= 1'b0;
            len_q       <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            wr_drop     <= 1'b0;
            tx.tx_start <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else begin
            trig_q  <= trig;
            done    <= 1'b0;
            aborted <= 1'b0;
            wr_drop <= wr_en & busy;

            // Abort outranks a same-cycle handoff: that byte is treated as not sent.
            if (busy && abort) begin
                state       <= IDLE;
                busy        <= 1'b0;
                aborted     <= 1'b1;
                tx.tx_start <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig_edge) begin
                            busy  <= 1'b1;
                            len_q <= len_clamped;
                            idx   <= '0;
                            if (len_clamped == '0) begin
`ifdef UART_MSG_CRLF_EN
                                state <= CR;
`else
                                state <= FIN;
`endif
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                    READ: begin
                        tx.tx_start <= 1'b1;
                        tx.tx_data  <= rd_data;
                        state       <= SEND;
                    end
                    SEND: begin
                        if (handoff) begin
                            tx.tx_start <= 1'b0;
                            idx         <= idx + AW'(1);
                            if (last_byte) begin
`ifdef UART_MSG_CRLF_EN
                                state <= CR;
`else
                                state <= FIN;
`endif
                            end else begin
                                state <= READ;
                            end
                        end
                    end
`ifdef UART_MSG_CRLF_EN
                    CR: begin
                        if (!tx.tx_start) begin
                            tx.tx_start <= 1'b1;
                            tx.tx_data  <= ASCII_CR;
                        end else if (handoff) begin
                            tx.tx_start <= 1'b0;
                            state       <= LF;
                        end
                    end
                    LF: begin
                        if (!tx.tx_start) begin
                            tx.tx_start <= 1'b1;
                            tx.tx_data  <= ASCII_LF;
                        end else if (handoff) begin
                            tx.tx_start <= 1'b0;
                            state       <= FIN;
                        end
                    end
`endif
                    FIN: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Directed bench for uart_msg_streamer: Hello message, len=0, stall, ignored trig/write, abort, clamp, reset.
module tb_uart_msg_streamer;
    import uart_msg_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int LW    = 9;
`ifdef UART_MSG_CRLF_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          trig;
    logic          abort;
    logic [LW-1:0] len;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_drop;
    logic          busy;
    logic          done;
    logic          aborted;

    uart_msg_streamer_if tx_if ();

    uart_msg_streamer #(.DEPTH(DEPTH)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .trig    (trig),
        .abort   (abort),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_drop (wr_drop),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .tx      (tx_if)
    );

    always #5 sys_clk = ~sys_clk;

    int         checks = 0;
    int         errors = 0;
    int         n_done = 0;
    int         n_abort = 0;
    logic [7:0] got[$];
    logic [7:0] hello[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record a handoff that the coming edge will perform, then sample 1 time unit after it.
    task automatic tick();
        if (tx_if.tx_start && tx_if.tx_ready && !(abort && busy)) got.push_back(tx_if.tx_data);
        @(posedge sys_clk);
        #1;
        if (done) n_done++;
        if (aborted) n_abort++;
    endtask

    task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk({tag, " done seen"}, done, 1);
    endtask

    function automatic logic [39:0] first5();
        return {got[0], got[1], got[2], got[3], got[4]};
    endfunction

    initial begin
        int unstable;
        int bad;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        sys_rst = 1'b1; trig = 1'b0; abort = 1'b0; len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; tx_if.tx_ready = 1'b1;
        tick(); tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst aborted", aborted, 0);
        chk("rst wr_drop", wr_drop, 0);
        chk("rst tx_start", tx_if.tx_start, 0);
        chk("rst tx_data", tx_if.tx_data, 8'h00);
        sys_rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) write_byte(AW'(i), hello[i]);

        // Hello, full speed; trig stays high afterwards and must not retrigger
        got.delete(); n_done = 0;
        len = 9'd5; trig = 1'b1;
        chk("hello busy at t", busy, 0);
        tick();
        chk("hello busy t+1", busy, 1);
        chk("hello no tx t+1", tx_if.tx_start, 0);
        tick();
        chk("hello tx_start t+2", tx_if.tx_start, 1);
        chk("hello byte0 t+2", tx_if.tx_data, 8'h48);
        run_until_done("hello", 60);
        chk("hello busy at done", busy, 0);
        chk("hello count", got.size(), 5 + EXTRA);
        chk("hello bytes", first5(), 40'h48656C6C6F);
`ifdef UART_MSG_CRLF_EN
        chk("hello crlf", {got[5], got[6]}, 16'h0D0A);
`endif
        tick();
        chk("hello done pulse", done, 0);
        tick(); tick(); tick();
        chk("hello no retrig", busy, 0);
        chk("hello done once", n_done, 1);

        // Zero length
        got.delete(); n_done = 0;
        trig = 1'b0; tick();
        len = 9'd0; trig = 1'b1;
        tick(); tick();
`ifdef UART_MSG_CRLF_EN
        run_until_done("len0", 30);
        chk("len0 crlf count", got.size(), 2);
        chk("len0 crlf bytes", {got[0], got[1]}, 16'h0D0A);
`else
        chk("len0 done t+2", done, 1);
        chk("len0 no bytes", got.size(), 0);
`endif
        chk("len0 done once", n_done, 1);

        // Transmitter stall on byte 1 for 20 cycles
        got.delete(); n_done = 0;
        trig = 1'b0; tick();
        len = 9'd5; trig = 1'b1;
        tick(); tick();
        tick();
        tx_if.tx_ready = 1'b0;
        tick();
        chk("stall tx_start", tx_if.tx_start, 1);
        chk("stall byte1", tx_if.tx_data, 8'h65);
        unstable = 0;
        repeat (20) begin
            tick();
            if (!tx_if.tx_start || tx_if.tx_data != 8'h65) unstable++;
        end
        chk("stall stable", unstable, 0);
        chk("stall count mid", got.size(), 1);
        tx_if.tx_ready = 1'b1;
        run_until_done("stall", 60);
        chk("stall count", got.size(), 5 + EXTRA);
        chk("stall bytes", first5(), 40'h48656C6C6F);
        chk("stall done once", n_done, 1);

        // Second trig edge and a write while busy
        got.delete(); n_done = 0;
        trig = 1'b0; tick();
        trig = 1'b1; tick(); tick();
        trig = 1'b0; tick();
        trig = 1'b1; wr_en = 1'b1; wr_addr = 8'd4; wr_data = 8'h58;
        tick();
        wr_en = 1'b0;
        chk("busy write wr_drop", wr_drop, 1);
        chk("busy write still busy", busy, 1);
        tick();
        chk("wr_drop pulse", wr_drop, 0);
        run_until_done("ignore", 60);
        chk("ignore bytes", first5(), 40'h48656C6C6F);
        tick(); tick(); tick();
        chk("ignore no queued trig", busy, 0);
        chk("ignore done once", n_done, 1);

        // Abort while byte 2 is on offer, then restart from byte 0
        got.delete(); n_done = 0; n_abort = 0;
        trig = 1'b0; tick();
        trig = 1'b1; tick();
        for (int k = 0; k < 30; k++) begin
            if (tx_if.tx_start && tx_if.tx_data == 8'h6C) break;
            tick();
        end
        chk("abort reached byte2", tx_if.tx_start, 1);
        chk("abort sent before", got.size(), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort tx_start low", tx_if.tx_start, 0);
        chk("abort pulse", aborted, 1);
        chk("abort busy low", busy, 0);
        tick();
        chk("abort pulse width", aborted, 0);
        chk("abort no done", n_done, 0);
        chk("abort byte not counted", got.size(), 2);
        abort = 1'b1; tick(); tick(); abort = 1'b0;
        chk("abort idle ignored", n_abort, 1);
        got.delete();
        trig = 1'b0; tick();
        trig = 1'b1; tick();
        run_until_done("restart", 60);
        chk("restart bytes", first5(), 40'h48656C6C6F);

        // Length above DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) write_byte(AW'(i), 8'(i * 7 + 3));
        got.delete(); n_done = 0;
        trig = 1'b0; tick();
        len = 9'(DEPTH + 5); trig = 1'b1;
        tick();
        run_until_done("clamp", 2000);
        chk("clamp count", got.size(), DEPTH + EXTRA);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (got[i] != 8'(i * 7 + 3)) bad++;
        chk("clamp bytes", bad, 0);

        // Reset in the middle of a message
        trig = 1'b0; tick();
        trig = 1'b1; tick();
        repeat (30) tick();
        chk("mid busy", busy, 1);
        sys_rst = 1'b1; trig = 1'b0;
        tick();
        chk("mid rst busy", busy, 0);
        chk("mid rst tx_start", tx_if.tx_start, 0);
        chk("mid rst tx_data", tx_if.tx_data, 8'h00);
        chk("mid rst done", done, 0);
        chk("mid rst aborted", aborted, 0);
        chk("mid rst wr_drop", wr_drop, 0);
        sys_rst = 1'b0; n_done = 0; n_abort = 0;
        repeat (10) tick();
        chk("post rst no done", n_done, 0);
        chk("post rst no abort", n_abort, 0);
        chk("post rst idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
